rst_sync_counter_gen: RTL and testbench

Parametrised reset-conditioning counter.
- Takes a raw asynchronous active-low reset.
- Produces a glitch-free internal reset: asserted asynchronously, released synchronously through a configurable synchroniser chain, then held for an extra stretch period.
- Provides an up/down counter with load, clear, enable, a programmable terminal value, and a wrap-or-saturate mode.
- Used wherever a module needs a cleanly released reset plus an event/timebase counter.

---
 rtl/rst_sync_counter_gen.sv | 115 +++++++++++
 tb/tb_rst_sync_counter_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sync_counter_gen.sv
// Reset conditioner with an up/down event counter.
// The internal reset asserts asynchronously, releases through a synchroniser and then holds for a stretch.
module rst_sync_counter_gen #(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     STRETCH     = 4,
    parameter longint unsigned MAX_VAL     = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SATURATE    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             rst_active
);

    if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
        $error("WIDTH must be in 2..63");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STRETCH > 255) begin : g_bad_stretch
        $error("STRETCH must not exceed 255");
    end
    if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("MAX_VAL must be below 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal     = WIDTH'(MAX_VAL);
    localparam logic [7:0]       StretchVal = 8'(STRETCH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             stretch_q, stretch_d;
    logic                   rst_active_q, rst_active_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   wrap_q, wrap_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};

    always_comb begin
        if (sync_q[SYNC_STAGES-1]) begin
            stretch_d = '0;
        end else if (stretch_q == StretchVal) begin
            stretch_d = stretch_q;
        end else begin
            stretch_d = stretch_q + 8'd1;
        end
    end

    // Built from next-state values so release lands on edge SYNC_STAGES+STRETCH.
    assign rst_active_d = sync_d[SYNC_STAGES-1] | (stretch_d != StretchVal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '1;
            stretch_q    <= '0;
            rst_active_q <= 1'b1;
        end else begin
            sync_q       <= sync_d;
            stretch_q    <= stretch_d;
            rst_active_q <= rst_active_d;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (rst_active_q) begin
            count_d = '0;
        end else if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count_q == MaxVal) begin
                    wrap_d  = 1'b1;
                    count_d = (SATURATE != 0) ? MaxVal : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d  = 1'b1;
                    count_d = (SATURATE != 0) ? '0 : MaxVal;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign wrap       = wrap_q;
    assign rst_active = rst_active_q;
    assign tc         = up_dn ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_rst_sync_counter_gen.sv
// Bench for rst_sync_counter_gen: four configurations share one clock and reset,
// checked against a cycle-level reference model plus directed vectors.
module tb_rst_sync_counter_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] en, up, load, clr;
    logic [7:0] lv [4];
    logic [3:0] tcv, wr, ra;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [3:0] cnt3;
    logic [7:0] cnt_v [4];

    always_comb begin
        cnt_v[0] = cnt0;
        cnt_v[1] = cnt1;
        cnt_v[2] = cnt2;
        cnt_v[3] = {4'b0000, cnt3};
    end

    // 0: defaults; 1: MAX_VAL=9 wrap; 2: MAX_VAL=9 saturate; 3: WIDTH=4, SYNC=3, STRETCH=0
    rst_sync_counter_gen u_def (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .up_dn(up[0]), .load(load[0]),
        .load_val(lv[0]), .clr(clr[0]), .count(cnt0), .tc(tcv[0]), .wrap(wr[0]),
        .rst_active(ra[0])
    );
    rst_sync_counter_gen #(.MAX_VAL(9), .SATURATE(0)) u_w9 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .up_dn(up[1]), .load(load[1]),
        .load_val(lv[1]), .clr(clr[1]), .count(cnt1), .tc(tcv[1]), .wrap(wr[1]),
        .rst_active(ra[1])
    );
    rst_sync_counter_gen #(.MAX_VAL(9), .SATURATE(1)) u_s9 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .up_dn(up[2]), .load(load[2]),
        .load_val(lv[2]), .clr(clr[2]), .count(cnt2), .tc(tcv[2]), .wrap(wr[2]),
        .rst_active(ra[2])
    );
    rst_sync_counter_gen #(.WIDTH(4), .SYNC_STAGES(3), .STRETCH(0), .SATURATE(0)) u_cfg (
        .clk(clk), .rst_n(rst_n), .en(en[3]), .up_dn(up[3]), .load(load[3]),
        .load_val(lv[3][3:0]), .clr(clr[3]), .count(cnt3), .tc(tcv[3]), .wrap(wr[3]),
        .rst_active(ra[3])
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: count, wrap and edges seen since reset release.
    int m_cnt [4];
    bit m_wrap [4];
    int m_edges;

    function automatic int maxv(int i);
        case (i)
            0:       return 255;
            3:       return 15;
            default: return 9;
        endcase
    endfunction

    function automatic bit sat(int i);
        return (i == 2);
    endfunction

    function automatic int hold(int i);
        return (i == 3) ? 3 : 6;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
        end
        m_edges = 0;
    endtask

    task automatic ref_next(input int i);
        int c;
        int mx;
        int l;
        bit w;
        c  = m_cnt[i];
        mx = maxv(i);
        l  = (i == 3) ? int'(lv[i]) % 16 : int'(lv[i]);
        w  = 1'b0;
        if (clr[i]) begin
            c = 0;
        end else if (load[i]) begin
            c = (l > mx) ? mx : l;
        end else if (en[i]) begin
            if (up[i]) begin
                if (c == mx) begin
                    w = 1'b1;
                    if (!sat(i)) c = 0;
                end else begin
                    c = c + 1;
                end
            end else begin
                if (c == 0) begin
                    w = 1'b1;
                    if (!sat(i)) c = mx;
                end else begin
                    c = c - 1;
                end
            end
        end
        m_cnt[i]  = c;
        m_wrap[i] = w;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_edges < hold(i)) begin
                m_cnt[i]  = 0;
                m_wrap[i] = 1'b0;
            end else begin
                ref_next(i);
            end
        end
        if (m_edges < 1000) m_edges++;
    endtask

    task automatic check_all();
        bit exp_tc;
        for (int i = 0; i < 4; i++) begin
            exp_tc = up[i] ? (m_cnt[i] == maxv(i)) : (m_cnt[i] == 0);
            check($sformatf("model_count%0d", i), 32'(cnt_v[i]), m_cnt[i]);
            check($sformatf("model_wrap%0d", i), 32'(wr[i]), 32'(m_wrap[i]));
            check($sformatf("model_rst_active%0d", i), 32'(ra[i]), 32'(m_edges < hold(i)));
            check($sformatf("model_tc%0d", i), 32'(tcv[i]), 32'(exp_tc));
        end
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic release_checks(input string tag);
        for (int k = 1; k <= 8; k++) begin
            step();
            check({tag, "_ra_def"}, 32'(ra[0]), 32'(k < 6));
            check({tag, "_cnt_def"}, 32'(cnt_v[0]), (k > 6) ? k - 6 : 0);
            if (k == 2) check({tag, "_ra_cfg_e2"}, 32'(ra[3]), 32'd1);
            if (k == 3) check({tag, "_ra_cfg_e3"}, 32'(ra[3]), 32'd0);
            if (k == 4) begin
                check({tag, "_cnt_cfg_underflow"}, 32'(cnt_v[3]), 32'd15);
                check({tag, "_wrap_cfg_underflow"}, 32'(wr[3]), 32'd1);
            end
        end
    endtask

    typedef struct packed {
        logic       en;
        logic       up;
        logic       ld;
        logic       cl;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       wr;
        logic       tc;
    } vec_t;

    function automatic vec_t mk(logic e, logic u, logic l, logic c, logic [7:0] v,
                                logic [7:0] n, logic w, logic t);
        vec_t r;
        r.en = e; r.up = u; r.ld = l; r.cl = c; r.lv = v; r.cnt = n; r.wr = w; r.tc = t;
        return r;
    endfunction

    vec_t tbl [12];

    initial begin
        int          sat_cnt [4];
        logic        sat_wr [4];
        logic        sat_tc [4];

        tbl[0]  = mk(0, 1, 1, 0,   8, 8, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0,   0, 9, 0, 1);
        tbl[2]  = mk(1, 1, 0, 0,   0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 1, 0,   6, 6, 0, 0);
        tbl[4]  = mk(1, 1, 1, 1,   5, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 200, 9, 0, 1);
        tbl[6]  = mk(1, 0, 0, 0,   0, 8, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1,   0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0,   0, 9, 1, 0);
        tbl[9]  = mk(0, 1, 1, 0,   9, 9, 0, 1);
        tbl[10] = mk(1, 1, 0, 0,   0, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0,   0, 0, 0, 1);

        sat_cnt = '{1, 0, 0, 0};
        sat_wr  = '{0, 0, 1, 1};
        sat_tc  = '{0, 1, 1, 1};

        rst_n = 1'b1;
        en = '0; up = '0; load = '0; clr = '0;
        for (int i = 0; i < 4; i++) lv[i] = '0;
        model_reset();

        #1 rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        check("reset_count_def", 32'(cnt_v[0]), 32'd0);
        check("reset_tc_down", 32'(tcv[0]), 32'd1);

        // Inputs during reset must be ignored.
        en[0] = 1'b1; up[0] = 1'b1; load[1] = 1'b1; lv[1] = 8'd7;
        en[3] = 1'b1; up[3] = 1'b0;
        @(negedge clk);
        step();
        step();
        load[1] = 1'b0;
        rst_n = 1'b1;
        release_checks("rel");
        en = '0;

        for (int v = 0; v < 12; v++) begin
            en[1] = tbl[v].en; up[1] = tbl[v].up; load[1] = tbl[v].ld;
            clr[1] = tbl[v].cl; lv[1] = tbl[v].lv;
            step();
            check($sformatf("vec%0d_count", v), 32'(cnt_v[1]), 32'(tbl[v].cnt));
            check($sformatf("vec%0d_wrap", v), 32'(wr[1]), 32'(tbl[v].wr));
            check($sformatf("vec%0d_tc", v), 32'(tcv[1]), 32'(tbl[v].tc));
        end
        en[1] = 1'b0; up[1] = 1'b0; load[1] = 1'b0; clr[1] = 1'b0;

        up[2] = 1'b0; load[2] = 1'b1; lv[2] = 8'd2;
        step();
        check("sat_load", 32'(cnt_v[2]), 32'd2);
        load[2] = 1'b0; en[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("sat%0d_count", k), 32'(cnt_v[2]), 32'(sat_cnt[k]));
            check($sformatf("sat%0d_wrap", k), 32'(wr[2]), 32'(sat_wr[k]));
            check($sformatf("sat%0d_tc", k), 32'(tcv[2]), 32'(sat_tc[k]));
        end
        en[2] = 1'b0;
        step();
        check("sat_wrap_drop", 32'(wr[2]), 32'd0);

        load[0] = 1'b1; lv[0] = 8'd57; up[0] = 1'b1;
        step();
        check("mid_load57", 32'(cnt_v[0]), 32'd57);
        load[0] = 1'b0; en[0] = 1'b1; en[3] = 1'b1; up[3] = 1'b0;
        // Short reset pulse entirely between clock edges.
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_async_count", 32'(cnt_v[0]), 32'd0);
        check("mid_async_ra", 32'(ra[0]), 32'd1);
        check_all();
        #2 rst_n = 1'b1;
        release_checks("mid");
        en = '0;

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                clr[i]  = ($urandom % 16) == 0;
                load[i] = ($urandom % 8) == 0;
                en[i]   = ($urandom % 4) != 0;
                up[i]   = $urandom % 2;
                case ($urandom % 4)
                    0:       lv[i] = 8'($urandom_range(0, 15));
                    1:       lv[i] = ($urandom % 2) ? 8'd255 : 8'd0;
                    default: lv[i] = 8'($urandom);
                endcase
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
